wb_bus_master: RTL and testbench

//  Initiator end of the single-beat io_bus used by the memory-mapped peripherals.
//  - Accepts one load/store request from the CPU memory stage and drives io_bus_addr, io_bus_dat2, io_bus_sel and io_bus_we.
//  - Waits for io_bus_ack, samples io_bus_dat4 for reads, then returns a one-cycle response.
//  - A watchdog ends any transaction whose slave never acks, so the pipeline cannot hang.

---
 rtl/wb_bus_pkg.sv | 26 ++
 rtl/wb_bus_master_if.sv | 22 ++
 rtl/wb_wait_counter.sv | 27 ++
 rtl/wb_bus_master.sv | 117 +++++++++++
 tb/tb_wb_bus_master.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_bus_pkg.sv
// Shared io_bus types: master FSM states, default widths and the request/response
// records used by the CPU-side initiator and the peripherals.
package wb_bus_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        HOLD = 2'd2,
        RESP = 2'd3
    } wb_mst_state_t;

    typedef struct packed {
        logic                  we;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
    } wb_req_t;

    typedef struct packed {
        logic                  err;
        logic [DEF_DATA_W-1:0] rdata;
    } wb_resp_t;

endpackage

// File: rtl/wb_bus_master_if.sv
// Single-beat io_bus wires between the initiator and a memory-mapped slave.
interface wb_bus_master_if #(
    parameter int ADDR_W = wb_bus_pkg::DEF_ADDR_W,
    parameter int DATA_W = wb_bus_pkg::DEF_DATA_W
);
    logic [ADDR_W-1:0] io_bus_addr;
    logic [DATA_W-1:0] io_bus_dat2;
    logic [DATA_W-1:0] io_bus_dat4;
    logic              io_bus_sel;
    logic              io_bus_we;
    logic              io_bus_ack;

    modport master (
        output io_bus_addr, io_bus_dat2, io_bus_sel, io_bus_we,
        input  io_bus_dat4, io_bus_ack
    );

    modport slave (
        input  io_bus_addr, io_bus_dat2, io_bus_sel, io_bus_we,
        output io_bus_dat4, io_bus_ack
    );
endinterface

// File: rtl/wb_wait_counter.sv
// Loadable saturating up/down counter with a terminal-count compare; serves both
// the no-ack watchdog and the read-hold delay.
module wb_wait_counter #(
    parameter int           W  = 4,
    parameter logic [W-1:0] TC = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         up,
    input  logic         down,
    output logic [W-1:0] count,
    output logic         tc
);
    // Saturates at both ends so a stalled count never wraps back into range.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                    count <= '0;
        else if (clr)                 count <= '0;
        else if (load)                count <= load_val;
        else if (up && count != '1)   count <= count + W'(1);
        else if (down && count != '0) count <= count - W'(1);
    end

    assign tc = (count == TC);
endmodule

// File: rtl/wb_bus_master.sv
// io_bus initiator: takes one CPU load/store, runs it on the bus with ack wait,
// optional read hold and a no-ack watchdog, then returns a one-cycle response.
module wb_bus_master
    import wb_bus_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 16,
    parameter int RD_LAT  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [DATA_W-1:0]  req_wdata,
    output logic               resp_valid,
    output logic [DATA_W-1:0]  resp_rdata,
    output logic               resp_err,
    wb_bus_master_if.master    bus
);
    localparam int              WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    // HOLD spans RD_LAT cycles, so the count starts one below and samples at zero.
    localparam logic [2:0]      HOLD_LOAD = (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;

    wb_mst_state_t     state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_tc;
    logic [2:0]        hold_cnt;
    logic              hold_tc;

    wb_wait_counter #(.W(WAIT_W), .TC(WAIT_LAST)) u_wait (
        .clk      (clk),
        .reset    (reset),
        .clr      (state == IDLE),
        .load     (1'b0),
        .load_val ('0),
        .up       (state == BUS),
        .down     (1'b0),
        .count    (wait_cnt),
        .tc       (wait_tc)
    );

    wb_wait_counter #(.W(3), .TC(3'd0)) u_hold (
        .clk      (clk),
        .reset    (reset),
        .clr      (state == IDLE),
        .load     (state == BUS && bus.io_bus_ack && !bus.io_bus_we),
        .load_val (HOLD_LOAD),
        .up       (1'b0),
        .down     (state == HOLD),
        .count    (hold_cnt),
        .tc       (hold_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            req_ready       <= 1'b1;
            resp_valid      <= 1'b0;
            resp_err        <= 1'b0;
            resp_rdata      <= '0;
            bus.io_bus_sel  <= 1'b0;
            bus.io_bus_we   <= 1'b0;
            bus.io_bus_addr <= '0;
            bus.io_bus_dat2 <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid && req_ready) begin
                    state           <= BUS;
                    req_ready       <= 1'b0;
                    bus.io_bus_sel  <= 1'b1;
                    bus.io_bus_we   <= req_we;
                    bus.io_bus_addr <= req_addr;
                    bus.io_bus_dat2 <= req_wdata;
                end
                BUS: begin
                    // Ack is tested first so an ack on the last watchdog cycle still completes.
                    if (bus.io_bus_ack) begin
                        if (bus.io_bus_we || RD_LAT == 0) begin
                            state          <= RESP;
                            resp_valid     <= 1'b1;
                            resp_err       <= 1'b0;
                            resp_rdata     <= bus.io_bus_we ? '0 : bus.io_bus_dat4;
                            bus.io_bus_sel <= 1'b0;
                            bus.io_bus_we  <= 1'b0;
                        end else begin
                            state <= HOLD;
                        end
                    end else if (wait_tc) begin
                        state          <= RESP;
                        resp_valid     <= 1'b1;
                        resp_err       <= 1'b1;
                        resp_rdata     <= '0;
                        bus.io_bus_sel <= 1'b0;
                        bus.io_bus_we  <= 1'b0;
                    end
                end
                HOLD: if (hold_tc) begin
                    state          <= RESP;
                    resp_valid     <= 1'b1;
                    resp_err       <= 1'b0;
                    resp_rdata     <= bus.io_bus_dat4;
                    bus.io_bus_sel <= 1'b0;
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_bus_master.sv
// Directed bench for wb_bus_master: table of single transactions against a
// registered-read slave model, plus back-to-back and reset-in-HOLD sequences.
module tb_wb_bus_master;
    import wb_bus_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int checks = 0;
    int errors = 0;

    wb_bus_master_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

    wb_bus_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16), .RD_LAT(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .bus        (bus_if)
    );

    always #5 clk = ~clk;

    // Slave: ack mode 0 = tied high, 1 = tied low, 2 = high only on sel cycle ack_at.
    int          ack_mode = 0;
    int          ack_at = 0;
    int          sel_run = 0;
    logic [31:0] mem [16];
    logic [31:0] dat4 = '0;

    assign bus_if.io_bus_ack  = (ack_mode == 0) ||
                                (ack_mode == 2 && bus_if.io_bus_sel && sel_run == ack_at);
    assign bus_if.io_bus_dat4 = dat4;

    always @(posedge clk) begin
        sel_run <= bus_if.io_bus_sel ? sel_run + 1 : 0;
        if (bus_if.io_bus_sel && !bus_if.io_bus_we)
            dat4 <= mem[bus_if.io_bus_addr[5:2]];
        if (bus_if.io_bus_sel && bus_if.io_bus_we && bus_if.io_bus_ack)
            mem[bus_if.io_bus_addr[5:2]] <= bus_if.io_bus_dat2;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        wb_req_t  req;
        int       mode;
        int       at;
        int       sel_cycles;
        int       resp_cycle;
        wb_resp_t exp;
    } vec_t;

    vec_t vecs[8];

    task automatic run_txn(input int idx, input vec_t v);
        int          sel_n = 0;
        int          resp_at = 0;
        logic        we_ok = 1'b1;
        logic [31:0] addr_s = '0;
        logic [31:0] dat2_s = '0;
        logic [31:0] rd_s = '0;
        logic        err_s = 1'b0;
        string       tag = $sformatf("v%0d", idx);
        @(negedge clk);
        ack_mode = v.mode;
        ack_at   = v.at;
        check({tag, "_ready_in"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = v.req.we;
        req_addr  = v.req.addr;
        req_wdata = v.req.wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 40 && resp_at == 0; k++) begin
            @(negedge clk);
            if (bus_if.io_bus_sel) begin
                sel_n++;
                if (sel_n == 1) begin
                    addr_s = bus_if.io_bus_addr;
                    dat2_s = bus_if.io_bus_dat2;
                end
                if (bus_if.io_bus_we !== v.req.we) we_ok = 1'b0;
            end
            if (resp_valid) begin
                resp_at = k;
                rd_s    = resp_rdata;
                err_s   = resp_err;
            end
        end
        check({tag, "_sel_cycles"}, 32'(sel_n), 32'(v.sel_cycles));
        check({tag, "_we_level"}, 32'(we_ok), 32'd1);
        check({tag, "_addr"}, addr_s, v.req.addr);
        if (v.req.we) check({tag, "_dat2"}, dat2_s, v.req.wdata);
        check({tag, "_resp_cycle"}, 32'(resp_at), 32'(v.resp_cycle));
        check({tag, "_rdata"}, rd_s, v.exp.rdata);
        check({tag, "_err"}, 32'(err_s), 32'(v.exp.err));
        @(negedge clk);
        check({tag, "_resp_one_cycle"}, 32'(resp_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(req_ready), 32'd1);
        check({tag, "_rdata_held"}, resp_rdata, v.exp.rdata);
    endtask

    initial begin
        vecs[0] = '{'{1'b1, 32'hFFFF_FE00, 32'h1234_5678}, 0, 0, 1, 2, '{1'b0, 32'h0}};
        vecs[1] = '{'{1'b0, 32'hFFFF_FE00, 32'h0}, 0, 0, 2, 3, '{1'b0, 32'h1234_5678}};
        vecs[2] = '{'{1'b0, 32'hFFFF_FE00, 32'h0}, 1, 0, 16, 17, '{1'b1, 32'h0}};
        vecs[3] = '{'{1'b0, 32'hFFFF_FE00, 32'h0}, 2, 15, 17, 18, '{1'b0, 32'h1234_5678}};
        vecs[4] = '{'{1'b1, 32'hFFFF_FE04, 32'hA5A5_0001}, 0, 0, 1, 2, '{1'b0, 32'h0}};
        vecs[5] = '{'{1'b0, 32'hFFFF_FE04, 32'h0}, 0, 0, 2, 3, '{1'b0, 32'hA5A5_0001}};
        vecs[6] = '{'{1'b1, 32'hFFFF_FE08, 32'hDEAD_BEEF}, 1, 0, 16, 17, '{1'b1, 32'h0}};
        vecs[7] = '{'{1'b0, 32'hFFFF_FE00, 32'h0}, 0, 0, 2, 3, '{1'b0, 32'h1234_5678}};

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_err", 32'(resp_err), 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_sel", 32'(bus_if.io_bus_sel), 32'd0);
        check("rst_we", 32'(bus_if.io_bus_we), 32'd0);
        check("rst_addr", bus_if.io_bus_addr, 32'd0);
        check("rst_dat2", bus_if.io_bus_dat2, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) run_txn(i, vecs[i]);

        // Back-to-back writes with req_valid held high.
        begin
            logic [31:0] wd [3];
            int n = 0, accepts = 0, resps = 0, sel_hi = 0, rises = 0;
            int acc_t [3];
            int resp_t [3];
            logic sel_prev = 1'b0, acc_next;
            wd[0] = 32'h1111_0000; wd[1] = 32'h2222_0000; wd[2] = 32'h3333_0000;
            @(negedge clk);
            ack_mode  = 0;
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_addr  = 32'h10;
            req_wdata = wd[0];
            for (int t = 0; t < 14; t++) begin
                if (t > 0) @(negedge clk);
                if (resp_valid) begin
                    if (resps < 3) resp_t[resps] = t;
                    resps++;
                end
                if (bus_if.io_bus_sel) sel_hi++;
                if (bus_if.io_bus_sel && !sel_prev) rises++;
                sel_prev = bus_if.io_bus_sel;
                acc_next = req_valid && req_ready;
                @(posedge clk);
                #1;
                if (acc_next) begin
                    if (accepts < 3) acc_t[accepts] = t;
                    accepts++;
                    n++;
                    if (n < 3) begin
                        req_addr  = 32'h10 + 32'(4 * n);
                        req_wdata = wd[n];
                    end else begin
                        req_valid = 1'b0;
                    end
                end
            end
            check("b2b_accepts", 32'(accepts), 32'd3);
            check("b2b_resps", 32'(resps), 32'd3);
            check("b2b_sel_cycles", 32'(sel_hi), 32'd3);
            check("b2b_sel_rises", 32'(rises), 32'd3);
            for (int j = 0; j < 3; j++) begin
                check($sformatf("b2b_acc%0d_cycle", j), 32'(acc_t[j]), 32'(3 * j));
                check($sformatf("b2b_resp%0d_cycle", j), 32'(resp_t[j]), 32'(3 * j + 2));
                check($sformatf("b2b_mem%0d", j), mem[4 + j], wd[j]);
            end
        end

        // Reset asserted while sel is high in HOLD.
        @(negedge clk);
        ack_mode  = 0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'hFFFF_FE00;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #3;
        check("hold_sel_before_rst", 32'(bus_if.io_bus_sel), 32'd1);
        reset = 1'b1;
        #1;
        check("async_sel", 32'(bus_if.io_bus_sel), 32'd0);
        check("async_we", 32'(bus_if.io_bus_we), 32'd0);
        check("async_resp_valid", 32'(resp_valid), 32'd0);
        check("async_ready", 32'(req_ready), 32'd1);
        check("async_rdata", resp_rdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        begin
            int spurious = 0;
            int sel_seen = 0;
            for (int t = 0; t < 5; t++) begin
                @(negedge clk);
                if (resp_valid) spurious++;
                if (bus_if.io_bus_sel) sel_seen++;
            end
            check("post_rst_no_resp", 32'(spurious), 32'd0);
            check("post_rst_no_sel", 32'(sel_seen), 32'd0);
            check("post_rst_ready", 32'(req_ready), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case a handshake never completes.
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end
endmodule
